// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a downstream combinational ALU: drives operands, waits
// SETTLE cycles, captures the result and hands it off, optionally sweeping every opcode.
module alu_cmd_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_s,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [WIDTH-1:0] res_s,
  output logic             busy,
  output logic             done,
  output logic [7:0]       res_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic [WIDTH-1:0] OP_LAST     = '1;
  localparam logic [WIDTH-1:0] OP_STEP     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             sweep_q, sweep_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] alu_s_q, alu_s_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_y_q, res_y_d;
  logic [WIDTH-1:0] res_s_q, res_s_d;
  logic             done_q, done_d;
  logic [7:0]       res_cnt_q, res_cnt_d;
  logic             last_result;

  // cmd_ready is held low during reset even though the state already reads IDLE
  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign last_result = !sweep_q || (alu_s_q == OP_LAST);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    sweep_d     = sweep_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_s_d     = res_s_q;
    res_cnt_d   = res_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_s_d  = cmd_sweep ? '0 : cmd_s;
          sweep_d  = cmd_sweep;
          settle_d = 4'd0;
          state_d  = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          res_y_d     = alu_y;
          res_s_d     = alu_s_q;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_cnt_d   = res_cnt_q + 8'd1;
          // The sweep ends on the terminal opcode compare rather than on a wrap
          if (last_result) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            alu_s_d  = alu_s_q + OP_STEP;
            settle_d = 4'd0;
            state_d  = S_DRIVE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 4'd0;
      sweep_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_s_q     <= '0;
      done_q      <= 1'b0;
      res_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      sweep_q     <= sweep_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_s_q     <= res_s_d;
      done_q      <= done_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_s     = res_s_q;
  assign done      = done_q;
  assign res_cnt   = res_cnt_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: operand, result and opcode width.
REQ-002 Parameter SETTLE, default 1 (legal 1..15): cycles alu_* are held stable before alu_y is sampled.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_a, cmd_b  input  WIDTH each  operands.
REQ-008 cmd_s  input  WIDTH  opcode for single mode.
REQ-009 cmd_sweep  input  1  1 = sweep opcodes 0..2^WIDTH-1; cmd_s is ignored.
REQ-010 alu_a, alu_b, alu_s  output  WIDTH each  registered operands/opcode to the downstream combinational ALU.
REQ-011 alu_y  input  WIDTH  ALU result.
REQ-012 res_valid  output  1  result present.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_y, res_s  output  WIDTH each  captured result and the opcode that produced it.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a command completes.
REQ-017 res_cnt  output  8  count of results handed off since reset.

Function
REQ-018 States SHALL be IDLE, DRIVE and OUT only; all outputs SHALL be registered, except cmd_ready and busy, which decode state.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge with cmd_valid=1 and cmd_ready=1.
REQ-020 On acceptance, alu_a/alu_b SHALL load cmd_a/cmd_b; alu_s SHALL load cmd_s in single mode or 0 in sweep mode; the mode bit is latched; state goes to DRIVE and the settle counter is cleared.
REQ-021 DRIVE SHALL last exactly SETTLE cycles with alu_a/alu_b/alu_s constant; on the edge ending the last DRIVE cycle: res_y <= alu_y, res_s <= alu_s, res_valid <= 1, state -> OUT.
REQ-022 Latency: command accepted at edge N -> res_valid high after edge N+SETTLE.
REQ-023 In OUT, res_valid, res_y and res_s SHALL hold until an edge with res_ready=1 (handoff); res_ready is ignored in all other states.
REQ-024 On handoff: res_valid <= 0 and res_cnt increments, wrapping 255 -> 0.
REQ-025 On handoff in single mode, or in sweep mode with alu_s = 2^WIDTH-1: state -> IDLE and done pulses for exactly one cycle.
REQ-026 On handoff in sweep mode with alu_s < 2^WIDTH-1: alu_s increments by 1 and state -> DRIVE (no IDLE cycle between results).
REQ-027 cmd_valid asserted while busy SHALL be ignored, with no state or output change.
REQ-028 res_ready=1 held continuously SHALL give one result per SETTLE+1 cycles.
REQ-029 Opcode arithmetic is modulo 2^WIDTH; the sweep terminates on the terminal-value compare and never wraps.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE; alu_a, alu_b, alu_s, res_y, res_s = 0; res_valid, done, busy, cmd_ready = 0; res_cnt = 0; settle counter = 0.
REQ-031 After rst falls, cmd_ready SHALL rise in the same cycle (IDLE decode).
REQ-032 rst asserted mid-command (in DRIVE or OUT) SHALL abort the command: no done pulse, and no result is delivered after release.

Verification
REQ-033 Single, SETTLE=1: a=12, b=2, s=0, res_ready=1 -> alu_a=12, alu_b=2, alu_s=0 after the accept edge; res_valid after edge N+1 with res_y = ALU(12,2,0) and res_s=0; done one cycle; res_cnt=1.
REQ-034 Sweep: a=12, b=2, cmd_sweep=1, res_ready=1 -> 16 results with res_s = 0..15 in order, one every 2 cycles; done once after res_s=15; res_cnt=16.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_valid, res_y and res_s stable; alu_s unchanged; res_cnt unchanged until the res_ready=1 edge.
REQ-036 Reset mid-sweep: assert rst while res_s=7 -> all outputs 0 immediately; no done pulse; cmd_ready=1 after release; a new single command then completes normally.
REQ-037 Busy rejection: pulse cmd_valid with a=3 during a sweep -> ignored; the sweep still delivers all 16 results with a=12.
REQ-038 Wrap and SETTLE: run 17 sweeps (272 results) -> res_cnt=16; with SETTLE=3, single command -> res_valid after edge N+3, and alu_* constant throughout DRIVE.
